down_counter_ctrl: RTL and testbench
====================================

Name: down_counter_ctrl

Overview:
Sequencing controller wrapped around a loadable synchronous down counter.
- Accepts a programmed start value and runs the count.
- Supports pause/resume, abort and optional auto-reload (periodic) operation.
- Flags terminal count and tallies completed periods.
- Sits between software/top-level control strobes and the counter datapath, so the rest of the lab design never drives the counter directly.

Parameters:
WIDTH, 4, counter/load value width in bits
PCNT_W, 8, width of the completed-period tally

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
load_val  input  WIDTH  start value, sampled only on an accepted start from IDLE
start  input  1  level, sampled each cycle: start from IDLE, resume from PAUSED
pause  input  1  level, sampled each cycle: suspend counting while RUN
abort  input  1  level, sampled each cycle: return to IDLE from any state
auto_reload  input  1  1 = reload and continue at terminal count; sampled at terminal cycle
count  output  WIDTH  current counter value (registered)
busy  output  1  1 when state != IDLE
done  output  1  terminal-count flag: 1 exactly while state==RUN and count==0
periods  output  PCNT_W  number of done cycles since last start from IDLE, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, reload_reg=0, periods=0. Outputs busy=0, done=0. Clock is ignored until rst=1.
- States: IDLE, RUN, PAUSED (2-bit encoding). All state and registers update on the rising edge of clk.
- Priority in every state: abort > terminal-count handling > pause > start.
- Any state, abort=1: next state IDLE, count<=0, periods held. No done is produced in the abort cycle, even if count==0.
- IDLE:
  - start=1: count<=load_val, reload_reg<=load_val, periods<=0, next RUN.
  - Otherwise: hold all registers. pause is ignored.
- RUN, count!=0:
  - pause=1: next PAUSED, count held (no decrement in that cycle).
  - Otherwise: count<=count-1, stay RUN. start is ignored in RUN.
- RUN, count==0 (terminal cycle):
  - done=1 and periods<=periods+1, saturating at 2^PCNT_W-1.
  - auto_reload=1: count<=reload_reg, stay RUN.
  - auto_reload=0: next IDLE, count stays 0.
  - pause asserted in the terminal cycle is ignored; the terminal action wins.
- PAUSED:
  - count held.
  - start=1: next RUN, with no reload; counting continues from the held value.
  - pause has no effect in PAUSED.
- Latency and period:
  - First RUN cycle shows count=load_val, one cycle after start is sampled.
  - One-shot: done appears load_val+1 cycles after the start edge.
  - Auto-reload period: load_val+1 cycles.
  - load_val=0 is legal: done asserts in the first RUN cycle. With auto_reload=1 it stays asserted every cycle.
- No wrap-around through 2^WIDTH-1 is ever produced. The decrement is only enabled when count!=0.
- Reset asserted mid-run: immediate return to the reset values, including periods=0.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, PAUSED=2'b10; 2'b11 is illegal and the FSM must recover to IDLE.
  - default WIDTH and PCNT_W.
- Sub-module down_counter_ld: WIDTH-bit register, async active-low reset to 0, inputs ld/ld_val/en, output q.
  - ld has priority over en.
  - en decrements by 1.
  - Built as the datapath so the controller contains only the FSM, reload register and period tally.

Test Plan:
- Reset then one-shot: rst low 1 cycle, load_val=3, start 1 cycle, auto_reload=0 -> count 3,2,1,0; done=1 only on the count==0 cycle; busy low the next cycle; periods=1.
- Auto-reload: load_val=2, auto_reload=1, start -> count 2,1,0,2,1,0,...; done every 3rd cycle; periods increments each time. Periods saturates at 255 after 255+ done cycles.
- Pause/resume: load_val=9, pause asserted when count=5 for 4 cycles -> count holds 5 in PAUSED. After start pulse, counting resumes 5,4,... with total done delay extended by exactly the paused cycles plus 1.
- Abort: abort at count=6 during RUN -> next cycle IDLE, count=0, busy=0, done never asserted. Repeat abort from PAUSED with the same result.
- Edge cases:
  - load_val=0 one-shot -> done in the first RUN cycle, then IDLE.
  - pause and count==0 in the same cycle -> done=1 and IDLE, not PAUSED.
  - start asserted while RUN -> ignored; the count sequence is unchanged.
- Async reset mid-run: drive rst=0 between clock edges at count=4 -> count=0, busy=0, periods=0 immediately. Release rst, then start with load_val=15 -> count 15 down to 0, with no value wrap past 0.

Source files
------------

// File: rtl/down_counter_ctrl_pkg.sv
// down_counter_ctrl_pkg: shared state encoding and default widths
package down_counter_ctrl_pkg;
  localparam int WIDTH_DEF  = 4;
  localparam int PCNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSED = 2'b10} state_t;
endpackage

// File: rtl/down_counter_ctrl_if.sv
// down_counter_ctrl_if: control strobes and status bundle for the counter controller
interface down_counter_ctrl_if import down_counter_ctrl_pkg::*; #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PCNT_W = PCNT_W_DEF
);
  logic [WIDTH-1:0]  load_val;
  logic              start;
  logic              pause;
  logic              abort;
  logic              auto_reload;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              done;
  logic [PCNT_W-1:0] periods;
  modport master (output load_val, start, pause, abort, auto_reload, input count, busy, done, periods);
  modport slave  (input load_val, start, pause, abort, auto_reload, output count, busy, done, periods);
endinterface

// File: rtl/down_counter_ld.sv
// down_counter_ld: loadable down counter datapath, load beats decrement
module down_counter_ld #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  // load has priority; decrement only when enabled
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else q <= ld ? ld_val : en ? q - 1'b1 : q;
endmodule

// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: sequencing FSM with reload and period tally around down_counter_ld
module down_counter_ctrl import down_counter_ctrl_pkg::*; #(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PCNT_W = PCNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  down_counter_ctrl_if.slave  bus
);
  state_t            state, nxt;
  logic [WIDTH-1:0]  reload_reg, ld_val;
  logic [PCNT_W-1:0] periods;
  logic              ld, en, go, tc;
  down_counter_ld #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .ld_val (ld_val),
    .en     (en),
    .q      (bus.count)
  );
  // terminal cycle is suppressed by abort, so abort never produces done
  assign tc           = state == RUN && bus.count == '0 && !bus.abort;
  assign bus.done     = tc;
  assign bus.busy     = state != IDLE;
  assign bus.periods  = periods;
  // next state and datapath controls: abort > terminal > pause > start
  always_comb begin
    nxt    = state;
    ld     = 1'b0;
    ld_val = reload_reg;
    en     = 1'b0;
    go     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        nxt    = RUN;
        ld     = 1'b1;
        ld_val = bus.load_val;
        go     = 1'b1;
      end
      RUN:
        if (bus.count == '0) begin
          nxt = bus.auto_reload ? RUN : IDLE;
          ld  = bus.auto_reload;
        end else if (bus.pause) nxt = PAUSED;
        else en = 1'b1;
      PAUSED: nxt = bus.start ? RUN : PAUSED;
      default: nxt = IDLE;
    endcase
    if (bus.abort) begin
      nxt    = IDLE;
      ld     = 1'b1;
      ld_val = '0;
      en     = 1'b0;
      go     = 1'b0;
    end
  end
  // state, reload value and saturating period tally
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      reload_reg <= '0;
      periods    <= '0;
    end else begin
      state      <= nxt;
      reload_reg <= go ? bus.load_val : reload_reg;
      periods    <= go ? '0 : (tc && periods != '1) ? periods + 1'b1 : periods;
    end
endmodule

// File: tb/tb_down_counter_ctrl.sv
// tb_down_counter_ctrl: scoreboard bench against a cycle model of the controller
module tb_down_counter_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  down_counter_ctrl_if #(.WIDTH(4), .PCNT_W(8)) bus ();
  down_counter_ctrl #(.WIDTH(4), .PCNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {int cnt; int busy; int per;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;
  int m_st = 0, m_cnt = 0, m_rel = 0, m_per = 0;
  int done_seen = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int s, input int p, input int a, input int r, input int lv);
    exp_t e;
    int ns, nc, nr, np, dn;
    @(negedge clk);
    bus.start = 1'(s);
    bus.pause = 1'(p);
    bus.abort = 1'(a);
    bus.auto_reload = 1'(r);
    bus.load_val = 4'(lv);
    #1;
    dn = (m_st == 1 && m_cnt == 0 && a == 0) ? 1 : 0;
    done_seen += dn;
    chk("done", int'(bus.done), dn);
    ns = m_st; nc = m_cnt; nr = m_rel; np = m_per;
    if (a != 0) begin
      ns = 0; nc = 0;
    end else if (m_st == 0) begin
      if (s != 0) begin ns = 1; nc = lv; nr = lv; np = 0; end
    end else if (m_st == 1) begin
      if (m_cnt == 0) begin
        if (m_per < 255) np = m_per + 1;
        if (r != 0) nc = m_rel;
        else ns = 0;
      end else if (p != 0) ns = 2;
      else nc = m_cnt - 1;
    end else if (s != 0) ns = 1;
    m_st = ns; m_cnt = nc; m_rel = nr; m_per = np;
    e.cnt = nc; e.busy = (ns != 0) ? 1 : 0; e.per = np;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("count", int'(bus.count), e.cnt);
    chk("busy", int'(bus.busy), e.busy);
    chk("periods", int'(bus.periods), e.per);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 0; bus.pause = 0; bus.abort = 0; bus.auto_reload = 0; bus.load_val = 0;
    #12;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_periods", int'(bus.periods), 0);
    @(negedge clk);
    rst = 1'b1;
    // one-shot of 3
    step(1, 0, 0, 0, 3);
    chk("first_run_count", int'(bus.count), 3);
    done_seen = 0;
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    chk("oneshot_done_cnt", done_seen, 1);
    chk("oneshot_periods", int'(bus.periods), 1);
    idle(1);
    // auto-reload period 3
    step(1, 0, 0, 1, 2);
    done_seen = 0;
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
    chk("reload_done_cnt", done_seen, 3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(1);
    // load 0 auto-reload saturates periods
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 260; i++) step(0, 0, 0, 1, 0);
    chk("sat_periods", int'(bus.periods), 255);
    step(0, 0, 1, 1, 0);
    // load 0 one-shot
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    idle(1);
    // pause at 5 for 4 cycles then resume
    step(1, 0, 0, 0, 9);
    for (int i = 0; i < 10 && m_cnt != 5; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("paused_count", int'(bus.count), 5);
    step(1, 0, 0, 0, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 7);
    chk("resume_done_cnt", done_seen, 1);
    // pause in terminal cycle
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // abort from RUN at 6
    step(1, 0, 0, 0, 8);
    for (int i = 0; i < 10 && m_cnt != 6; i++) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("abort_run_busy", int'(bus.busy), 0);
    // abort from PAUSED
    step(1, 0, 0, 0, 8);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("abort_pause_count", int'(bus.count), 0);
    // abort exactly at terminal count
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(2);
    // async reset mid-run at count 4
    step(1, 0, 0, 0, 9);
    for (int i = 0; i < 10 && m_cnt != 4; i++) step(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_count", int'(bus.count), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_periods", int'(bus.periods), 0);
    m_st = 0; m_cnt = 0; m_rel = 0; m_per = 0;
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0, 15);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0);
    chk("final_count", int'(bus.count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
